// File: rtl/dds_pkg.sv
// Shared types and helpers for the DDS phase controller.
// DDS_DITHER_EN selects the LFSR phase-dither constants used by dds_phase_acc.
package dds_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as a bit mask on lfsr[15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [31:0] phase_to_addr(input logic [63:0] phase,
                                                  input int          pw,
                                                  input int          aw);
        return 32'(phase >> (pw - aw));
    endfunction

endpackage

// File: rtl/dds_phase_acc.sv
// Phase accumulator, FCW register and offset add producing the registered RAM read address.
// DDS_DITHER_EN adds LFSR dither to the phase below the address bits before truncation.
module dds_phase_acc
    import dds_pkg::*;
#(
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run_en,
    input  logic                   fcw_valid,
    input  logic [PHASE_WIDTH-1:0] fcw,
    input  logic [PHASE_WIDTH-1:0] phase_off,
    input  logic                   phase_clr,
    output logic [ADDR_WIDTH-1:0]  addrb
);

    logic [PHASE_WIDTH-1:0] acc;
    logic [PHASE_WIDTH-1:0] fcw_reg;
    logic [PHASE_WIDTH-1:0] phase;

`ifdef DDS_DITHER_EN
    localparam logic [PHASE_WIDTH-1:0] DITHER_MASK =
        (PHASE_WIDTH'(1) << (PHASE_WIDTH - ADDR_WIDTH)) - PHASE_WIDTH'(1);

    logic [15:0] lfsr;

    always_comb begin
        phase = acc + phase_off + (PHASE_WIDTH'(lfsr) & DITHER_MASK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else if (run_en) begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end
`else
    always_comb begin
        phase = acc + phase_off;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            fcw_reg <= '0;
            addrb   <= '0;
        end else begin
            if (fcw_valid) begin
                fcw_reg <= fcw;
            end
            // clear wins over accumulation; a simultaneous fcw update still lands
            if (phase_clr) begin
                acc <= '0;
            end else if (run_en) begin
                acc <= acc + fcw_reg;
            end
            if (run_en) begin
                addrb <= ADDR_WIDTH'(phase_to_addr(64'(phase), PHASE_WIDTH, ADDR_WIDTH));
            end
        end
    end

endmodule

// File: rtl/dds_phase_ctrl.sv
// DDS controller: table load into RAM, run sequencing and valid-qualified sample re-timing.
// DDS_DITHER_EN enables phase dither inside dds_phase_acc.
module dds_phase_ctrl
    import dds_pkg::*;
#(
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int RAM_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_start,
    input  logic                   load_valid,
    input  logic [DATA_WIDTH-1:0]  load_data,
    output logic                   load_ready,
    output logic                   table_loaded,
    input  logic                   run,
    input  logic                   fcw_valid,
    input  logic [PHASE_WIDTH-1:0] fcw,
    input  logic [PHASE_WIDTH-1:0] phase_off,
    input  logic                   phase_clr,
    output logic                   wen,
    output logic [ADDR_WIDTH-1:0]  addra,
    output logic [DATA_WIDTH-1:0]  din,
    output logic [ADDR_WIDTH-1:0]  addrb,
    input  logic [DATA_WIDTH-1:0]  ram_dout,
    output logic [DATA_WIDTH-1:0]  sample,
    output logic                   sample_valid
);

    localparam int VDEPTH = RAM_LATENCY + 2;

    state_t                state;
    logic [ADDR_WIDTH-1:0] wcnt;
    logic [VDEPTH-1:0]     vpipe;
    logic                  run_en;

    assign run_en       = (state == RUN);
    assign sample_valid = vpipe[VDEPTH-1];

    dds_phase_acc #(
        .PHASE_WIDTH (PHASE_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_acc (
        .clk       (clk),
        .rst       (rst),
        .run_en    (run_en),
        .fcw_valid (fcw_valid),
        .fcw       (fcw),
        .phase_off (phase_off),
        .phase_clr (phase_clr),
        .addrb     (addrb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            load_ready   <= 1'b0;
            table_loaded <= 1'b0;
            wen          <= 1'b0;
            addra        <= '0;
            din          <= '0;
            wcnt         <= '0;
        end else begin
            wen <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state      <= LOAD;
                        load_ready <= 1'b1;
                    end else if (run && table_loaded) begin
                        state <= RUN;
                    end
                end
                LOAD: begin
                    if (load_valid && load_ready) begin
                        wen   <= 1'b1;
                        addra <= wcnt;
                        din   <= load_data;
                        wcnt  <= wcnt + ADDR_WIDTH'(1);
                        if (wcnt == '1) begin
                            table_loaded <= 1'b1;
                            load_ready   <= 1'b0;
                            state        <= IDLE;
                        end
                    end
                end
                RUN: begin
                    if (!run) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    load_ready <= 1'b0;
                end
            endcase
        end
    end

    // one valid per issued address; the sample is captured as its RAM data arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe  <= '0;
            sample <= '0;
        end else begin
            vpipe <= {vpipe[VDEPTH-2:0], run_en};
            if (vpipe[VDEPTH-2]) begin
                sample <= ram_dout;
            end
        end
    end

endmodule

// File: tb/tb_dds_phase_ctrl.sv
// Self-checking bench for dds_phase_ctrl (default build, DDS_DITHER_EN undefined).
// Burst expectations come from phase arithmetic: sample k = table[(acc0 + k*fcw + off) >> 22].
module tb_dds_phase_ctrl;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_ready;
    logic        table_loaded;
    logic        run = 1'b0;
    logic        fcw_valid = 1'b0;
    logic [31:0] fcw = '0;
    logic [31:0] phase_off = '0;
    logic        phase_clr = 1'b0;
    logic        wen;
    logic [9:0]  addra;
    logic [31:0] din;
    logic [9:0]  addrb;
    logic [31:0] ram_dout = '0;
    logic [31:0] sample;
    logic        sample_valid;

    logic [31:0] tbl [DEPTH];
    logic [31:0] mem [DEPTH];
    logic [31:0] got [$];
    int          gotc [$];

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          wexp = 0;
    int          wbeats = 0;
    logic [31:0] macc = '0;
    logic [31:0] mfcw = '0;

    dds_phase_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .load_start   (load_start),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_ready   (load_ready),
        .table_loaded (table_loaded),
        .run          (run),
        .fcw_valid    (fcw_valid),
        .fcw          (fcw),
        .phase_off    (phase_off),
        .phase_clr    (phase_clr),
        .wen          (wen),
        .addra        (addra),
        .din          (din),
        .addrb        (addrb),
        .ram_dout     (ram_dout),
        .sample       (sample),
        .sample_valid (sample_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // simple dual-port RAM, one cycle read latency
    always @(posedge clk) begin
        if (wen) mem[addra] <= din;
        ram_dout <= mem[addrb];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (wen) begin
                chk("addra", 64'(addra), 64'(wexp));
                chk("din", 64'(din), 64'(tbl[wexp[9:0]]));
                wexp++;
                wbeats++;
            end
            if (sample_valid) begin
                got.push_back(sample);
                gotc.push_back(cyc);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; run = 1'b0; load_start = 1'b0; load_valid = 1'b0;
        fcw_valid = 1'b0; phase_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        macc = '0; mfcw = '0; wexp = 0; wbeats = 0;
    endtask

    task automatic load_table(input int lim);
        int  sent;
        int  guard;
        bit  go;
        bit  beat;
        sent = 0; guard = 0; wexp = 0; wbeats = 0;
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        chk("load_ready_on", 64'(load_ready), 64'(1));
        while (sent < lim && guard < 8000) begin
            go = ($urandom_range(0, 3) != 0);
            load_valid = go;
            load_data = go ? tbl[sent[9:0]] : $urandom;
            beat = go && load_ready;
            @(negedge clk);
            guard++;
            if (beat) sent++;
        end
        load_valid = 1'b0;
        chk("load_beats_sent", 64'(sent), 64'(lim));
    endtask

    task automatic burst(input int n, input logic [31:0] f, input logic [31:0] off, input bit clr);
        int          c0;
        int          w;
        int          wb0;
        logic [31:0] p;
        @(negedge clk);
        fcw = f; fcw_valid = 1'b1; phase_off = off; phase_clr = clr;
        @(negedge clk);
        fcw_valid = 1'b0; phase_clr = 1'b0; fcw = $urandom;
        mfcw = f;
        if (clr) macc = '0;
        got.delete(); gotc.delete();
        wb0 = wbeats;
        run = 1'b1; load_valid = 1'b1; c0 = cyc;
        for (int k = 0; k < n; k++) begin
            load_start = (k == 1);
            @(negedge clk);
        end
        run = 1'b0; load_start = 1'b0; load_valid = 1'b0;
        w = 0;
        while (got.size() < n && w < 20) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        chk("n_samples", 64'(got.size()), 64'(n));
        if (got.size() > 0) begin
            chk("first_valid_latency", 64'(gotc[0] - c0), 64'(4));
            chk("valid_contiguous", 64'(gotc[got.size()-1] - gotc[0]), 64'(got.size() - 1));
        end
        for (int k = 0; k < n && k < got.size(); k++) begin
            p = macc + 32'(k) * mfcw + off;
            chk("sample", 64'(got[k]), 64'(tbl[p[31:22]]));
        end
        p = macc + 32'(n - 1) * mfcw + off;
        chk("addrb_hold", 64'(addrb), 64'(p[31:22]));
        chk("no_write_in_run", 64'(wbeats), 64'(wb0));
        chk("load_ready_run", 64'(load_ready), 64'(0));
        chk("valid_drained", 64'(sample_valid), 64'(0));
        macc = macc + 32'(n) * mfcw;
    endtask

    initial begin
        do_reset();
        chk("rst_load_ready", 64'(load_ready), 64'(0));
        chk("rst_table_loaded", 64'(table_loaded), 64'(0));
        chk("rst_wen", 64'(wen), 64'(0));
        chk("rst_addra", 64'(addra), 64'(0));
        chk("rst_din", 64'(din), 64'(0));
        chk("rst_addrb", 64'(addrb), 64'(0));
        chk("rst_sample", 64'(sample), 64'(0));
        chk("rst_sample_valid", 64'(sample_valid), 64'(0));

        // load_valid outside LOAD and run without a table are both ignored
        got.delete();
        @(negedge clk);
        load_valid = 1'b1; load_data = 32'hDEAD_BEEF; run = 1'b1;
        repeat (8) @(negedge clk);
        load_valid = 1'b0; run = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_valid_dropped", 64'(wbeats), 64'(0));
        chk("run_no_table", 64'(got.size()), 64'(0));

        for (int i = 0; i < DEPTH; i++) tbl[i] = 32'(i * i);
        load_table(DEPTH);
        repeat (2) @(negedge clk);
        chk("load_beats", 64'(wbeats), 64'(DEPTH));
        chk("table_loaded", 64'(table_loaded), 64'(1));
        chk("load_ready_off", 64'(load_ready), 64'(0));

        burst(1030, 32'h0040_0000, 32'h0, 1'b0);
        burst(8, 32'h8000_0000, 32'h0, 1'b1);
        burst(6, 32'h0, 32'h4000_0000, 1'b1);
        chk("const_addr", 64'(addrb), 64'(256));
        burst(5, 32'h0040_0000, 32'h0, 1'b1);
        burst(5, 32'h0040_0000, 32'h0, 1'b0);
        for (int r = 0; r < 8; r++)
            burst(int'($urandom_range(1, 40)), $urandom, $urandom, 1'($urandom_range(0, 1)));

        // reset part-way through a reload drops table_loaded and blocks RUN
        for (int i = 0; i < DEPTH; i++) tbl[i] = $urandom;
        load_table(5);
        do_reset();
        chk("midload_table_loaded", 64'(table_loaded), 64'(0));
        got.delete();
        @(negedge clk);
        run = 1'b1;
        repeat (10) @(negedge clk);
        run = 1'b0;
        repeat (5) @(negedge clk);
        chk("midload_no_run", 64'(got.size()), 64'(0));
        chk("midload_addrb", 64'(addrb), 64'(0));

        load_table(DEPTH);
        repeat (2) @(negedge clk);
        chk("reload_table_loaded", 64'(table_loaded), 64'(1));
        for (int r = 0; r < 4; r++)
            burst(int'($urandom_range(1, 40)), $urandom, $urandom, 1'($urandom_range(0, 1)));

        // reset while running flushes the valid pipeline immediately
        @(negedge clk);
        run = 1'b1;
        repeat (6) @(negedge clk);
        chk("pre_rst_valid", 64'(sample_valid), 64'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_run_valid", 64'(sample_valid), 64'(0));
        chk("rst_run_addrb", 64'(addrb), 64'(0));
        chk("rst_run_sample", 64'(sample), 64'(0));
        chk("rst_run_table_loaded", 64'(table_loaded), 64'(0));
        @(negedge clk);
        rst = 1'b0; run = 1'b0;
        macc = '0; mfcw = '0;
        repeat (4) @(negedge clk);
        chk("post_rst_idle_valid", 64'(sample_valid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
